ex_type_i: RTL and testbench

//  Execute stage for RV32 I-type ALU ops (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI).

---
 rtl/ex_type_i.sv | 190 +++++++++++++++++++
 tb/tb_ex_type_i.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_type_i.sv
// RV32 I-type ALU execute stage with a valid/ready output register and synchronous flush.
// Define SERIAL_SHIFT_EN to replace the barrel shifter with an iterative 1-bit shifter (IDLE/BUSY FSM).
module ex_type_i #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic            arith_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            reg_we_i,
    input  logic [AW-1:0]   reg_waddr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_waddr_o,
    output logic [XLEN-1:0] wb_wdata_o
);

    localparam int SW = $clog2(XLEN);

    localparam logic [2:0] INST_ADD  = 3'b000;
    localparam logic [2:0] INST_SLL  = 3'b001;
    localparam logic [2:0] INST_SLT  = 3'b010;
    localparam logic [2:0] INST_SLTU = 3'b011;
    localparam logic [2:0] INST_XOR  = 3'b100;
    localparam logic [2:0] INST_SRI  = 3'b101;
    localparam logic [2:0] INST_OR   = 3'b110;
    localparam logic [2:0] INST_AND  = 3'b111;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg, state_next;
    logic            accept;
    logic            we_dec;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] sra_result;
    logic [XLEN-1:0] alu_result;

    logic            start_serial;
    logic            serial_done;
    logic            load_out;
    logic            load_we;
    logic [AW-1:0]   load_waddr;
    logic [XLEN-1:0] load_data;

    logic            out_valid_reg;
    logic            wb_we_reg;
    logic [AW-1:0]   wb_waddr_reg;
    logic [XLEN-1:0] wb_wdata_reg;

    assign in_ready_o = (state_reg == IDLE) && !flush_i && (!out_valid_reg || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    // x0 is hard-wired to zero, so a write to it is never enabled
    assign we_dec     = reg_we_i && (reg_waddr_i != '0);
    assign shamt      = op2_i[SW-1:0];
    // Kept as a standalone assignment so the arithmetic shift stays in a signed context
    assign sra_result = $signed(op1_i) >>> shamt;

    always_comb begin
        alu_result = '0;
        case (funct3_i)
            INST_ADD:  alu_result = op1_i + op2_i;
            INST_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
            INST_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
            INST_XOR:  alu_result = op1_i ^ op2_i;
            INST_OR:   alu_result = op1_i | op2_i;
            INST_AND:  alu_result = op1_i & op2_i;
            INST_SLL:  alu_result = op1_i << shamt;
            INST_SRI:  alu_result = arith_i ? sra_result : (op1_i >> shamt);
            default:   alu_result = '0;
        endcase
    end

`ifdef SERIAL_SHIFT_EN
    logic            is_shift;
    logic [XLEN-1:0] sh_reg;
    logic [XLEN-1:0] sh_step;
    logic [SW-1:0]   cnt_reg;
    logic            sh_left_reg;
    logic            sh_arith_reg;
    logic            sh_we_reg;
    logic [AW-1:0]   sh_waddr_reg;

    assign is_shift     = (funct3_i == INST_SLL) || (funct3_i == INST_SRI);
    assign start_serial = accept && is_shift;
    assign serial_done  = (cnt_reg == '0);

    // One-bit shift step; the MSB is replicated for arithmetic right shifts
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign sh_step[gi] = sh_left_reg ? 1'b0 : sh_reg[gi+1];
            end else if (gi == XLEN-1) begin : g_msb
                assign sh_step[gi] = sh_left_reg ? sh_reg[gi-1] : (sh_arith_reg & sh_reg[gi]);
            end else begin : g_mid
                assign sh_step[gi] = sh_left_reg ? sh_reg[gi-1] : sh_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_reg       <= '0;
            cnt_reg      <= '0;
            sh_left_reg  <= 1'b0;
            sh_arith_reg <= 1'b0;
            sh_we_reg    <= 1'b0;
            sh_waddr_reg <= '0;
        end else if (start_serial) begin
            sh_reg       <= op1_i;
            cnt_reg      <= shamt;
            sh_left_reg  <= (funct3_i == INST_SLL);
            sh_arith_reg <= arith_i;
            sh_we_reg    <= we_dec;
            sh_waddr_reg <= reg_waddr_i;
        end else if (flush_i) begin
            cnt_reg      <= '0;
        end else if ((state_reg == BUSY) && !serial_done) begin
            sh_reg       <= sh_step;
            cnt_reg      <= cnt_reg - 1'b1;
        end
    end

    assign load_out   = (accept && !is_shift) || ((state_reg == BUSY) && serial_done);
    assign load_we    = (state_reg == BUSY) ? sh_we_reg    : we_dec;
    assign load_waddr = (state_reg == BUSY) ? sh_waddr_reg : reg_waddr_i;
    assign load_data  = (state_reg == BUSY) ? sh_reg       : alu_result;
`else
    assign start_serial = 1'b0;
    assign serial_done  = 1'b1;
    assign load_out     = accept;
    assign load_we      = we_dec;
    assign load_waddr   = reg_waddr_i;
    assign load_data    = alu_result;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start_serial) state_next = BUSY;
                BUSY:    if (serial_done)  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output register: flush beats load; load beats retire so a handshake and accept overlap
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            wb_we_reg     <= 1'b0;
            wb_waddr_reg  <= '0;
            wb_wdata_reg  <= '0;
        end else if (flush_i) begin
            out_valid_reg <= 1'b0;
            wb_we_reg     <= 1'b0;
        end else if (load_out) begin
            out_valid_reg <= 1'b1;
            wb_we_reg     <= load_we;
            wb_waddr_reg  <= load_waddr;
            wb_wdata_reg  <= load_data;
        end else if (out_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_reg;
    assign wb_we_o     = wb_we_reg;
    assign wb_waddr_o  = wb_waddr_reg;
    assign wb_wdata_o  = wb_wdata_reg;

endmodule

// File: tb/tb_ex_type_i.sv
// Self-checking bench for ex_type_i: directed vector table, back-pressure/flush sequences,
// and randomized traffic scored against a behavioural model.
module tb_ex_type_i;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'd0;
    logic        arith = 1'b0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic        reg_we = 1'b0;
    logic [4:0]  reg_waddr = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    int checks = 0;
    int failures = 0;

    ex_type_i #(.XLEN(32), .AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .funct3_i    (funct3),
        .arith_i     (arith),
        .op1_i       (op1),
        .op2_i       (op2),
        .reg_we_i    (reg_we),
        .reg_waddr_i (reg_waddr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .wb_we_o     (wb_we),
        .wb_waddr_o  (wb_waddr),
        .wb_wdata_o  (wb_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        ar;
        logic [31:0] a;
        logic [31:0] b;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        we;
        logic [4:0]  wa;
    } res_t;

    vec_t vecs[12];
    res_t sb[$];

`ifdef SERIAL_SHIFT_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference: double-width extension, then plain shifts/compares
    function automatic logic [31:0] model(input logic [2:0] f3, input logic ar,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] w;
        int unsigned sh;
        logic [31:0] r;
        sh = b[4:0];
        case (f3)
            3'd0: r = a + b;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd6: r = a | b;
            3'd7: r = a & b;
            3'd1: begin w = {32'd0, a} << sh; r = w[31:0]; end
            default: begin
                w = ar ? {{32{a[31]}}, a} : {32'd0, a};
                w = w >> sh;
                r = w[31:0];
            end
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] b);
        if (SERIAL && (f3 == 3'd1 || f3 == 3'd5)) return int'(b[4:0]) + 2;
        return 1;
    endfunction

    // Starts just after a negedge; returns at the negedge following the accepting edge
    task automatic issue(input logic [2:0] f3, input logic ar, input logic [31:0] a,
                         input logic [31:0] b, input logic we, input logic [4:0] wa,
                         output bit ok);
        funct3 = f3; arith = ar; op1 = a; op2 = b; reg_we = we; reg_waddr = wa;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL issue_timeout actual=in_ready_low expected=accept");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        bit ok;
        int lat;
        bit saw_valid;
        bit hold_pending;
        res_t hold_val;
        res_t exp_r;
        logic [2:0] rf3;
        logic rar;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b1, 5'd3,  32'h80000000, 1'b1};
        vecs[1]  = '{3'd2, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 5'd4,  32'h00000001, 1'b1};
        vecs[2]  = '{3'd3, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 5'd5,  32'h00000000, 1'b1};
        vecs[3]  = '{3'd7, 1'b0, 32'hF0F0F0F0, 32'hFFFFF0FF, 1'b1, 5'd6,  32'hF0F0F0F0, 1'b1};
        vecs[4]  = '{3'd5, 1'b1, 32'h80000000, 32'h00000404, 1'b1, 5'd7,  32'hF8000000, 1'b1};
        vecs[5]  = '{3'd5, 1'b0, 32'h80000000, 32'h00000004, 1'b1, 5'd8,  32'h08000000, 1'b1};
        vecs[6]  = '{3'd1, 1'b0, 32'h00000001, 32'h0000001F, 1'b1, 5'd9,  32'h80000000, 1'b1};
        vecs[7]  = '{3'd0, 1'b0, 32'h00000005, 32'h00000006, 1'b1, 5'd0,  32'h0000000B, 1'b0};
        vecs[8]  = '{3'd4, 1'b0, 32'h0F0F0F0F, 32'hFFFF0000, 1'b1, 5'd10, 32'hF0F00F0F, 1'b1};
        vecs[9]  = '{3'd6, 1'b0, 32'h12340000, 32'h00005678, 1'b1, 5'd31, 32'h12345678, 1'b1};
        vecs[10] = '{3'd5, 1'b1, 32'h80000000, 32'hFFFFFFE0, 1'b1, 5'd11, 32'h80000000, 1'b1};
        vecs[11] = '{3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd7,  32'hFFFFFFFE, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_wb_we", {31'd0, wb_we}, 32'd0);
        check("reset_wb_waddr", {27'd0, wb_waddr}, 32'd0);
        check("reset_wb_wdata", wb_wdata, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].f3, vecs[i].ar, vecs[i].a, vecs[i].b, vecs[i].we, vecs[i].wa, ok);
            if (!ok) continue;
            if (exp_lat(vecs[i].f3, vecs[i].b) > 1) begin
                #1;
                check($sformatf("vec%0d_busy_ready", i), {31'd0, in_ready}, 32'd0);
            end
            wait_result(lat);
            check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].f3, vecs[i].b));
            check($sformatf("vec%0d_data", i), wb_wdata, vecs[i].exp_data);
            check($sformatf("vec%0d_we", i), {31'd0, wb_we}, {31'd0, vecs[i].exp_we});
            check($sformatf("vec%0d_waddr", i), {27'd0, wb_waddr}, {27'd0, vecs[i].wa});
            @(negedge clk);
            check($sformatf("vec%0d_retire", i), {31'd0, out_valid}, 32'd0);
        end

        // Back-pressure with a second op pending; release gives same-edge retire+accept
        out_ready = 1'b0;
        issue(3'd0, 1'b0, 32'd100, 32'd23, 1'b1, 5'd9, ok);
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        funct3 = 3'd0; op1 = 32'd1000; op2 = 32'hFFFFFFFF; reg_we = 1'b1; reg_waddr = 5'd10;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_ready_c%0d", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp_hold_data_c%0d", k), wb_wdata, 32'd123);
            check($sformatf("bp_hold_waddr_c%0d", k), {27'd0, wb_waddr}, 32'd9);
            check($sformatf("bp_hold_valid_c%0d", k), {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_second_data", wb_wdata, 32'd999);
        check("bp_second_waddr", {27'd0, wb_waddr}, 32'd10);
        @(negedge clk);
        check("bp_second_retire", {31'd0, out_valid}, 32'd0);

        // Flush a held result while an op is offered: nothing accepted, valid/we cleared
        out_ready = 1'b0;
        issue(3'd0, 1'b0, 32'd5, 32'd5, 1'b1, 5'd4, ok);
        check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        funct3 = 3'd0; op1 = 32'd1; op2 = 32'd1; reg_we = 1'b1; reg_waddr = 5'd2;
        in_valid = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_wb_we", {31'd0, wb_we}, 32'd0);
        issue(3'd0, 1'b0, 32'd7, 32'd8, 1'b1, 5'd12, ok);
        wait_result(lat);
        check("post_flush_latency", lat, 32'd1);
        check("post_flush_data", wb_wdata, 32'd15);
        @(negedge clk);

`ifdef SERIAL_SHIFT_EN
        // Kill a long serial shift on its 3rd BUSY cycle, by flush then by reset
        for (int rep = 0; rep < 2; rep++) begin
            issue(3'd1, 1'b0, 32'd1, 32'd31, 1'b1, 5'd6, ok);
            @(negedge clk);
            @(negedge clk);
            if (rep == 0) flush = 1'b1; else rst = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            rst = 1'b0;
            #1;
            check($sformatf("kill%0d_in_ready", rep), {31'd0, in_ready}, 32'd1);
            saw_valid = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (out_valid) saw_valid = 1'b1;
            end
            check($sformatf("kill%0d_no_valid", rep), {31'd0, saw_valid}, 32'd0);
            issue(3'd0, 1'b0, 32'd40, 32'd2, 1'b1, 5'd1, ok);
            wait_result(lat);
            check($sformatf("kill%0d_addi_latency", rep), lat, 32'd1);
            check($sformatf("kill%0d_addi_data", rep), wb_wdata, 32'd42);
            @(negedge clk);
        end
`endif

        // Randomized traffic with random back-pressure, scored against the model
        hold_pending = 1'b0;
        hold_val = '{32'd0, 1'b0, 5'd0};
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (hold_pending) begin
                check("rand_hold_valid", {31'd0, out_valid}, 32'd1);
                check("rand_hold_data", wb_wdata, hold_val.data);
                check("rand_hold_waddr", {27'd0, wb_waddr}, {27'd0, hold_val.wa});
                hold_pending = 1'b0;
            end
            rf3 = 3'($urandom_range(0, 7));
            rar = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            funct3 = rf3; arith = rar; op1 = ra; op2 = rb;
            reg_we = 1'($urandom_range(0, 1));
            reg_waddr = 5'($urandom_range(0, 31));
            in_valid = (cyc < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rand_unexpected_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_r = sb.pop_front();
                    check("rand_data", wb_wdata, exp_r.data);
                    check("rand_we", {31'd0, wb_we}, {31'd0, exp_r.we});
                    check("rand_waddr", {27'd0, wb_waddr}, {27'd0, exp_r.wa});
                end
            end else if (out_valid) begin
                hold_pending = 1'b1;
                hold_val = '{wb_wdata, wb_we, wb_waddr};
            end
            if (in_valid && in_ready) begin
                sb.push_back('{model(rf3, rar, ra, rb), reg_we && (reg_waddr != 5'd0), reg_waddr});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && (sb.size() != 0 || out_valid); k++) begin
            if (out_valid) begin
                exp_r = sb.pop_front();
                check("drain_data", wb_wdata, exp_r.data);
            end
            @(negedge clk);
        end
        check("rand_scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
